sample_deserializer: RTL

// Collects a serial stream of BIT_WIDTH samples into one N_SAMPLES-wide parallel frame
// for the Pease FFT datapath. It sits directly upstream of the butterfly/stride-permutation

---
 rtl/sample_deserializer_pkg.sv | 14 +
 rtl/sample_deserializer.sv | 69 ++++++
 2 files changed

// File: rtl/sample_deserializer_pkg.sv
// Shared helpers for the Pease FFT datapath blocks.
package sample_deserializer_pkg;

  // Reverse the low 'width' bits of value; the bits above width come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_deserializer.sv
// Serial-to-parallel frame collector ahead of the Pease FFT stages.
// A single buffer alternates between filling (RECV) and presenting a whole frame (SEND).
module sample_deserializer
  import sample_deserializer_pkg::*;
#(
  parameter int N_SAMPLES   = 8,
  parameter int BIT_WIDTH   = 32,
  parameter int BIT_REVERSE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam logic [0:0] ST_RECV = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [CNT_W-1:0]     w_idx;
  logic                 w_recv_xfer;
  logic                 w_send_xfer;
  logic [BIT_WIDTH-1:0] r_buf [N_SAMPLES];

  assign recv_rdy = (r_state == ST_RECV);
  assign send_val = (r_state == ST_SEND);

  always_comb begin
    w_recv_xfer = recv_val && (r_state == ST_RECV);
    w_send_xfer = send_rdy && (r_state == ST_SEND);
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (BIT_REVERSE != 0) w_idx = CNT_W'(bit_reverse(32'(r_count), CNT_W));
    else                  w_idx = r_count;
    if (w_recv_xfer) begin
      // Count is a power-of-two width, so the last sample wraps it to zero naturally.
      w_count_nxt = r_count + 1'b1;
      if (r_count == CNT_W'(N_SAMPLES - 1)) w_state_nxt = ST_SEND;
    end
    if (w_send_xfer) w_state_nxt = ST_RECV;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RECV;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_buf
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                    r_buf[i] <= '0;
      else if (w_recv_xfer && (w_idx == CNT_W'(i)))  r_buf[i] <= recv_msg;
    end
    assign send_msg[i] = r_buf[i];
  end

endmodule
